riscv_pipeline_ctrl: RTL and testbench
======================================

Name: riscv_pipeline_ctrl

Overview:
- Hazard and stall controller that drives the hold and clear inputs of every pipeline-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Decides each cycle whether a stage register captures, holds, or is cleared to a bubble.
- Sources of decisions: data-memory wait, multi-cycle mul/div wait, taken branch, load-use hazard, instruction-memory wait.
- Holds a small FSM for multi-cycle operations, a timeout counter and a stall-cycle performance counter.

Parameters:
MD_TIMEOUT  64  cycles allowed in MD_WAIT before abort
CNT_W       32  width of stall performance counter

Ports:
i_clk              in   1      clock, all state on rising edge
i_rst              in   1      synchronous active-high reset
i_id_rs1           in   5      rs1 index of instruction in ID
i_id_rs2           in   5      rs2 index of instruction in ID
i_id_use_rs1       in   1      ID instruction reads rs1
i_id_use_rs2       in   1      ID instruction reads rs2
i_ex_rd            in   5      rd index of instruction in EX
i_ex_is_load       in   1      EX instruction is a load
i_ex_br_taken      in   1      EX resolved a taken branch/jump
i_md_start         in   1      EX issues mul/div (one-cycle pulse)
i_md_done          in   1      mul/div result valid
i_imem_ready       in   1      instruction fetch data valid this cycle
i_dmem_req         in   1      MEM stage has an access outstanding
i_dmem_ready       in   1      data memory completes access
o_hold_pc          out  1      1 = PC holds
o_hold_ifid        out  1      1 = IF/ID holds (register hold-enable semantics: 1 holds, 0 captures)
o_hold_idex        out  1      1 = ID/EX holds
o_hold_exmem       out  1      1 = EX/MEM holds
o_clr_ifid         out  1      1 = IF/ID loads bubble
o_clr_idex         out  1      1 = ID/EX loads bubble
o_clr_exmem        out  1      1 = EX/MEM loads bubble
o_clr_memwb        out  1      1 = MEM/WB loads bubble
o_md_timeout       out  1      one-cycle pulse on MD abort
o_stall_cnt        out  CNT_W  count of cycles with o_hold_pc=1

Behaviour:
- Hold/clear outputs are combinational from state and inputs. State, timeout counter and o_stall_cnt are registered.
- While i_rst=1, outputs are forced:
  - all o_hold_* = 0 and all o_clr_* = 1;
  - o_md_timeout = 0.
- On the first edge with i_rst=1: state<=RUN, timeout counter<=0, o_stall_cnt<=0.
- FSM states: RUN, MD_WAIT.
  - RUN->MD_WAIT on i_md_start when no dmem stall.
  - MD_WAIT->RUN on i_md_done, or when timeout counter reaches MD_TIMEOUT-1.
  - Timeout counter is cleared on MD_WAIT entry and increments every MD_WAIT cycle.
- Priority, highest first; exactly one rule applies per cycle:
  1. Dmem stall (i_dmem_req & !i_dmem_ready), any state:
     - hold pc, ifid, idex, exmem; clr_memwb=1.
     - Branch, load-use and md_start are ignored this cycle. EX is frozen, so they re-present.
     - In MD_WAIT the timeout counter still increments.
  2. MD_WAIT without i_md_done and without timeout:
     - hold pc, ifid, idex; clr_exmem=1.
  3. MD_WAIT with i_md_done or timeout: no holds, no clears (result advances).
     - On timeout: o_md_timeout=1 this cycle only.
     - On same-cycle done and timeout, done wins and no o_md_timeout.
  4. RUN, i_md_start: hold pc, ifid, idex; clr_exmem=1; next state MD_WAIT.
  5. RUN, i_ex_br_taken:
     - clr_ifid=1, clr_idex=1; pc not held (loads target).
     - Overrides load-use and imem wait.
  6. RUN, load-use: i_ex_is_load & i_ex_rd!=0 & ((i_id_use_rs1 & rs1==rd) | (i_id_use_rs2 & rs2==rd)).
     - hold pc, ifid; clr_idex=1. Exactly one bubble.
  7. RUN, !i_imem_ready: hold pc; clr_ifid=1.
  8. Otherwise all outputs 0.
- A hold and a clear are never both asserted on the same stage register.
- o_stall_cnt increments on each edge where o_hold_pc=1 and i_rst=0; saturates at all-ones.
- i_rst mid-MD_WAIT returns to RUN next cycle; an in-flight done is then ignored.

Test Plan:
1. Reset then idle (imem_ready=1, no hazards) -> all outputs 0 after reset; o_stall_cnt=0; during reset all clr=1, holds=0.
2. EX load rd=5, ID use_rs1 rs1=5 -> one cycle hold_pc=hold_ifid=clr_idex=1; next cycle (EX no longer load) all 0; o_stall_cnt=1. Same stimulus with rd=0 -> no stall.
3. md_start, done 4 cycles later -> 4 cycles of hold_pc/ifid/idex + clr_exmem; done cycle all 0; state RUN; o_stall_cnt +4.
4. md_start, no done, MD_TIMEOUT=64 -> stall releases after 64 cycles total with o_md_timeout pulsed once; done and timeout on same cycle -> no pulse.
5. dmem_req=1, ready=0 for 3 cycles while br_taken=1 -> 3 cycles hold pc/ifid/idex/exmem + clr_memwb, no clr_ifid; cycle ready rises -> clr_ifid=clr_idex=1.
6. Branch taken and load-use together -> only clr_ifid/clr_idex; imem_ready=0 alone -> hold_pc=clr_ifid=1; force o_stall_cnt near all-ones (CNT_W=4) -> saturates at 15.

Source files
------------

// File: rtl/riscv_pipeline_ctrl.sv
// Hazard/stall controller driving hold and clear of every pipeline register.
// Ports: i_clk/i_rst, ID/EX hazard info, md/imem/dmem status in;
//   o_hold_* / o_clr_* per stage, o_md_timeout pulse, o_stall_cnt out.
module riscv_pipeline_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_is_load,
    input  logic             i_ex_br_taken,
    input  logic             i_md_start,
    input  logic             i_md_done,
    input  logic             i_imem_ready,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    output logic             o_hold_pc,
    output logic             o_hold_ifid,
    output logic             o_hold_idex,
    output logic             o_hold_exmem,
    output logic             o_clr_ifid,
    output logic             o_clr_idex,
    output logic             o_clr_exmem,
    output logic             o_clr_memwb,
    output logic             o_md_timeout,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic dmem_stall;
    logic tmo_hit;
    logic load_use;

    assign dmem_stall = i_dmem_req & ~i_dmem_ready;
    assign tmo_hit    = (state_q == MD_WAIT) && (tmo_q == TMO_MAX);
    assign load_use   = i_ex_is_load && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        o_hold_pc    = 1'b0;
        o_hold_ifid  = 1'b0;
        o_hold_idex  = 1'b0;
        o_hold_exmem = 1'b0;
        o_clr_ifid   = 1'b0;
        o_clr_idex   = 1'b0;
        o_clr_exmem  = 1'b0;
        o_clr_memwb  = 1'b0;
        o_md_timeout = 1'b0;

        // Counter keeps running through dmem stalls; it parks at the
        // limit so the abort still fires once memory releases.
        if (state_q == MD_WAIT && tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end

        priority case (1'b1)
            dmem_stall: begin
                o_hold_pc    = 1'b1;
                o_hold_ifid  = 1'b1;
                o_hold_idex  = 1'b1;
                o_hold_exmem = 1'b1;
                o_clr_memwb  = 1'b1;
            end
            (state_q == MD_WAIT) && !i_md_done && !tmo_hit: begin
                o_hold_pc    = 1'b1;
                o_hold_ifid  = 1'b1;
                o_hold_idex  = 1'b1;
                o_clr_exmem  = 1'b1;
            end
            (state_q == MD_WAIT): begin
                // Done beats a coincident timeout: no abort pulse.
                state_d      = RUN;
                o_md_timeout = tmo_hit & ~i_md_done;
            end
            i_md_start: begin
                state_d      = MD_WAIT;
                tmo_d        = '0;
                o_hold_pc    = 1'b1;
                o_hold_ifid  = 1'b1;
                o_hold_idex  = 1'b1;
                o_clr_exmem  = 1'b1;
            end
            i_ex_br_taken: begin
                o_clr_ifid   = 1'b1;
                o_clr_idex   = 1'b1;
            end
            load_use: begin
                o_hold_pc    = 1'b1;
                o_hold_ifid  = 1'b1;
                o_clr_idex   = 1'b1;
            end
            !i_imem_ready: begin
                o_hold_pc    = 1'b1;
                o_clr_ifid   = 1'b1;
            end
            default: begin
            end
        endcase

        if (i_rst) begin
            o_hold_pc    = 1'b0;
            o_hold_ifid  = 1'b0;
            o_hold_idex  = 1'b0;
            o_hold_exmem = 1'b0;
            o_clr_ifid   = 1'b1;
            o_clr_idex   = 1'b1;
            o_clr_exmem  = 1'b1;
            o_clr_memwb  = 1'b1;
            o_md_timeout = 1'b0;
        end

        cnt_d = cnt_q;
        if (o_hold_pc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// Self-checking bench for riscv_pipeline_ctrl (CNT_W=4, MD_TIMEOUT=64).
// Expected output patterns queued per cycle, compared at the falling edge.
module tb_riscv_pipeline_ctrl;

    localparam int CNT_W = 4;

    // {hold pc,ifid,idex,exmem, clr ifid,idex,exmem,memwb, md_timeout}
    localparam logic [8:0] P_NONE = 9'b0000_0000_0;
    localparam logic [8:0] P_RST  = 9'b0000_1111_0;
    localparam logic [8:0] P_LU   = 9'b1100_0100_0;
    localparam logic [8:0] P_MD   = 9'b1110_0010_0;
    localparam logic [8:0] P_DM   = 9'b1111_0001_0;
    localparam logic [8:0] P_BR   = 9'b0000_1100_0;
    localparam logic [8:0] P_IM   = 9'b1000_1000_0;
    localparam logic [8:0] P_TO   = 9'b0000_0000_1;

    logic i_clk;
    logic i_rst;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
    logic i_id_use_rs1, i_id_use_rs2, i_ex_is_load, i_ex_br_taken;
    logic i_md_start, i_md_done, i_imem_ready, i_dmem_req, i_dmem_ready;
    logic o_hold_pc, o_hold_ifid, o_hold_idex, o_hold_exmem;
    logic o_clr_ifid, o_clr_idex, o_clr_exmem, o_clr_memwb;
    logic o_md_timeout;
    logic [CNT_W-1:0] o_stall_cnt;

    logic [8:0] dut_outs;
    assign dut_outs = {o_hold_pc, o_hold_ifid, o_hold_idex, o_hold_exmem,
                       o_clr_ifid, o_clr_idex, o_clr_exmem, o_clr_memwb,
                       o_md_timeout};

    riscv_pipeline_ctrl #(.MD_TIMEOUT(64), .CNT_W(CNT_W)) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_ex_rd       (i_ex_rd),
        .i_ex_is_load  (i_ex_is_load),
        .i_ex_br_taken (i_ex_br_taken),
        .i_md_start    (i_md_start),
        .i_md_done     (i_md_done),
        .i_imem_ready  (i_imem_ready),
        .i_dmem_req    (i_dmem_req),
        .i_dmem_ready  (i_dmem_ready),
        .o_hold_pc     (o_hold_pc),
        .o_hold_ifid   (o_hold_ifid),
        .o_hold_idex   (o_hold_idex),
        .o_hold_exmem  (o_hold_exmem),
        .o_clr_ifid    (o_clr_ifid),
        .o_clr_idex    (o_clr_idex),
        .o_clr_exmem   (o_clr_exmem),
        .o_clr_memwb   (o_clr_memwb),
        .o_md_timeout  (o_md_timeout),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        string            tag;
        logic [8:0]       outs;
        logic [CNT_W-1:0] cnt;
        logic             cnt_valid;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic cnt_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        i_rst = 1'b0;
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0;
        i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0;
        i_ex_is_load = 1'b0; i_ex_br_taken = 1'b0;
        i_md_start = 1'b0; i_md_done = 1'b0;
        i_imem_ready = 1'b1; i_dmem_req = 1'b0; i_dmem_ready = 1'b0;
    endtask

    // Inputs are already driven; queue expectation, check, advance a cycle.
    task automatic step(input string tag, input logic [8:0] exp);
        exp_t e;
        exp_t g;
        e.tag = tag;
        e.outs = exp;
        e.cnt = exp_cnt;
        e.cnt_valid = cnt_known;
        sb.push_back(e);
        @(negedge i_clk);
        g = sb.pop_front();
        chk({g.tag, "_outs"}, 32'(dut_outs), 32'(g.outs));
        if (g.cnt_valid) chk({g.tag, "_cnt"}, 32'(o_stall_cnt), 32'(g.cnt));
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            exp_cnt = '0;
            cnt_known = 1'b1;
        end else if (exp[8] && exp_cnt != '1) begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    initial begin
        idle_in();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        // 1: reset then idle
        step("rst0", P_RST);
        step("rst1", P_RST);
        idle_in();
        step("idle0", P_NONE);
        step("idle1", P_NONE);

        // 2: load-use on rs1, then rd=0, then rs2 variants
        i_ex_is_load = 1'b1; i_ex_rd = 5'd5;
        i_id_use_rs1 = 1'b1; i_id_rs1 = 5'd5;
        step("lu_rs1", P_LU);
        idle_in();
        step("lu_after", P_NONE);
        i_ex_is_load = 1'b1; i_ex_rd = 5'd0;
        i_id_use_rs1 = 1'b1; i_id_rs1 = 5'd0;
        step("lu_x0", P_NONE);
        idle_in();
        i_ex_is_load = 1'b1; i_ex_rd = 5'd7;
        i_id_use_rs2 = 1'b1; i_id_rs2 = 5'd7;
        step("lu_rs2", P_LU);
        idle_in();
        i_ex_is_load = 1'b1; i_ex_rd = 5'd9; i_id_rs1 = 5'd9;
        step("lu_nouse", P_NONE);
        idle_in();

        // 3: md with done four cycles after start
        i_md_start = 1'b1;
        step("md_start", P_MD);
        i_md_start = 1'b0;
        for (int i = 0; i < 3; i++) step("md_wait", P_MD);
        i_md_done = 1'b1;
        step("md_done", P_NONE);
        i_md_done = 1'b0;
        step("md_run", P_NONE);

        // 5: dmem stall masks a branch; branch acts when ready rises
        i_dmem_req = 1'b1; i_ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) step("dm_stall", P_DM);
        i_dmem_ready = 1'b1;
        step("dm_release", P_BR);
        idle_in();

        // 6: branch beats load-use; imem wait alone
        i_ex_br_taken = 1'b1;
        i_ex_is_load = 1'b1; i_ex_rd = 5'd3;
        i_id_use_rs1 = 1'b1; i_id_rs1 = 5'd3;
        step("br_lu", P_BR);
        idle_in();
        i_imem_ready = 1'b0;
        step("imem", P_IM);
        idle_in();

        // dmem stall masks md_start; start re-presented afterwards
        i_dmem_req = 1'b1; i_md_start = 1'b1;
        step("dm_md", P_DM);
        i_dmem_req = 1'b0;
        step("md_start2", P_MD);
        i_md_start = 1'b0; i_md_done = 1'b1;
        step("md_done2", P_NONE);
        idle_in();

        // 4: timeout with no done; counter saturates along the way
        i_md_start = 1'b1;
        step("to_start", P_MD);
        i_md_start = 1'b0;
        for (int i = 0; i < 63; i++) step("to_wait", P_MD);
        step("to_fire", P_TO);
        step("to_after", P_NONE);
        step("cnt_sat", P_NONE);

        // done coincident with timeout: no pulse
        i_md_start = 1'b1;
        step("tod_start", P_MD);
        i_md_start = 1'b0;
        for (int i = 0; i < 63; i++) step("tod_wait", P_MD);
        i_md_done = 1'b1;
        step("tod_both", P_NONE);
        i_md_done = 1'b0;
        step("tod_after", P_NONE);

        // reset mid MD_WAIT; a late done is ignored in RUN
        i_md_start = 1'b1;
        step("rmd_start", P_MD);
        i_md_start = 1'b0;
        step("rmd_wait", P_MD);
        i_rst = 1'b1; i_md_done = 1'b1;
        step("rmd_rst", P_RST);
        i_rst = 1'b0;
        step("rmd_done", P_NONE);
        idle_in();
        step("rmd_idle", P_NONE);
        i_imem_ready = 1'b0;
        step("rmd_imem", P_IM);
        idle_in();
        step("rmd_cnt", P_NONE);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
